// File: rtl/id_ex_hazard_stage.sv
// ID/EX boundary for RV32I: register file with write-through bypass, a registered
// slot with valid/ready handshake, load-use bubbles, flush and held-operand refresh.
// Optional HAZARD_STATS_EN adds saturating bubble/hold counters.
module id_ex_hazard_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CTRL_W   = 64,
    parameter int RIDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [RIDX_W-1:0] ex_rs1,
    output logic [RIDX_W-1:0] ex_rs2,
    output logic [RIDX_W-1:0] ex_rd,
    output logic              ex_is_load,
    input  logic              wb_load,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stat_bubbles,
    output logic [31:0]       stat_holds
`endif
);

    // Handshake: a transfer happens on a clock edge where valid && ready are both
    // high; valid never depends on ready, and the slot holds steady while
    // ex_valid && !ex_ready. A flush consumes the decoder word regardless.

    logic [XLEN-1:0]   r_regs [NUM_REGS];

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [XLEN-1:0]   r_rs1_val;
    logic [XLEN-1:0]   r_rs2_val;
    logic [RIDX_W-1:0] r_rs1;
    logic [RIDX_W-1:0] r_rs2;
    logic [RIDX_W-1:0] r_rd;
    logic              r_is_load;
    logic              r_uses_rs1;
    logic              r_uses_rs2;

    logic              w_adv;
    logic              w_haz;
    logic              w_wb_en;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;

    function automatic logic [XLEN-1:0] rf_read(input logic [RIDX_W-1:0] idx);
        if (idx == '0)
            return '0;
        else if (wb_load && (wb_rd == idx))
            return wb_data;
        else
            return r_regs[idx];
    endfunction

    always_comb begin
        w_wb_en   = wb_load && (wb_rd != '0);
        w_rs1_val = rf_read(id_rs1);
        w_rs2_val = rf_read(id_rs2);
        w_adv     = !r_valid || ex_ready;
        w_haz     = r_valid && r_is_load && (r_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == r_rd)) ||
                     (id_uses_rs2 && (id_rs2 == r_rd)));
        id_ready  = flush || (w_adv && !w_haz);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wb_en) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_rs1_val  <= '0;
            r_rs2_val  <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_is_load  <= 1'b0;
            r_uses_rs1 <= 1'b0;
            r_uses_rs2 <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_haz || !id_valid) begin
                r_valid <= 1'b0;
            end else begin
                r_valid    <= 1'b1;
                r_ctrl     <= id_ctrl;
                r_rs1_val  <= w_rs1_val;
                r_rs2_val  <= w_rs2_val;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
                r_is_load  <= id_is_load;
                r_uses_rs1 <= id_uses_rs1;
                r_uses_rs2 <= id_uses_rs2;
            end
        end else begin
            // Held slot: pick up writebacks landing on our sources so the
            // operands are current when execute finally takes them.
            if (w_wb_en && r_uses_rs1 && (wb_rd == r_rs1)) r_rs1_val <= wb_data;
            if (w_wb_en && r_uses_rs2 && (wb_rd == r_rs2)) r_rs2_val <= wb_data;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_ctrl    = r_ctrl;
    assign ex_rs1_val = r_rs1_val;
    assign ex_rs2_val = r_rs2_val;
    assign ex_rs1     = r_rs1;
    assign ex_rs2     = r_rs2;
    assign ex_rd      = r_rd;
    assign ex_is_load = r_is_load;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stat_bubbles;
    logic [31:0] r_stat_holds;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_bubbles <= '0;
            r_stat_holds   <= '0;
        end else begin
            if (w_adv && w_haz && (r_stat_bubbles != '1))
                r_stat_bubbles <= r_stat_bubbles + 32'd1;
            if (r_valid && !ex_ready && (r_stat_holds != '1))
                r_stat_holds <= r_stat_holds + 32'd1;
        end
    end

    assign stat_bubbles = r_stat_bubbles;
    assign stat_holds   = r_stat_holds;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: expected slot contents are queued at
// issue time and popped by a monitor whenever execute consumes the slot.
module tb_id_ex_hazard_stage;

  localparam int W = 144;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [63:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_is_load;
  logic        flush, ex_ready, ex_valid;
  logic [63:0] ex_ctrl;
  logic [31:0] ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_is_load;
  logic        wb_load;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_bubbles, stat_holds;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  id_ex_hazard_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef HAZARD_STATS_EN
    , .stat_bubbles(stat_bubbles), .stat_holds(stat_holds)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(input logic [63:0] c, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [4:0] d,
                                      input logic ld);
    return {c, a, b, s1, s2, d, ld};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready && !flush) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL slot_unexpected: got %h with empty queue at %0t",
                 pk(ex_ctrl, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2, ex_rd, ex_is_load), $time);
      end else begin
        logic [W-1:0] e, a;
        e = exp_q.pop_front();
        a = pk(ex_ctrl, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2, ex_rd, ex_is_load);
        if (a === e) n_pass++;
        else $display("FAIL slot_contents: got %h expected %h at %0t", a, e, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    wb_load = 1'b1; wb_rd = rd; wb_data = d;
    step();
    wb_load = 1'b0;
  endtask

  task automatic set_id(input logic [63:0] c, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic u1, input logic u2, input logic ld);
    id_ctrl = c; id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_is_load = ld; id_valid = 1'b1;
  endtask

  // Present one instruction that is expected to be accepted immediately.
  task automatic send(input logic [63:0] c, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic u1, input logic u2, input logic ld);
    set_id(c, s1, s2, d, u1, u2, ld);
    @(negedge clk);
    chk("id_ready_accept", 64'(id_ready), 64'd1);
    step();
    id_valid = 1'b0;
  endtask

  // Load (rs1=x5) with destination ld_rd, followed directly by a dependent candidate.
  task automatic load_use(input logic [63:0] c_ld, input logic [4:0] ld_rd,
                          input logic [63:0] c_add, input logic [4:0] s1, input logic [4:0] s2,
                          input logic u1, input logic u2, input logic bubble,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] x5);
    exp_q.push_back(pk(c_ld, x5, 32'h0, 5'd5, 5'd0, ld_rd, 1'b1));
    send(c_ld, 5'd5, 5'd0, ld_rd, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(pk(c_add, v1, v2, s1, s2, 5'd12, 1'b0));
    set_id(c_add, s1, s2, 5'd12, u1, u2, 1'b0);
    @(negedge clk);
    chk("id_ready_hazard", 64'(id_ready), 64'(!bubble));
    if (bubble) begin
      step();
      @(negedge clk);
      chk("bubble_valid", 64'(ex_valid), 64'd0);
      chk("id_ready_after_bubble", 64'(id_ready), 64'd1);
    end
    step();
    id_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; id_valid = 1'b0; id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_is_load = 1'b0;
    flush = 1'b0; ex_ready = 1'b1; wb_load = 1'b0; wb_rd = '0; wb_data = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_ctrl", ex_ctrl, 64'd0);
    chk("rst_ex_rs1_val", 64'(ex_rs1_val), 64'd0);
    chk("rst_ex_rd", 64'(ex_rd), 64'd0);
    chk("rst_id_ready", 64'(id_ready), 64'd1);
    step();
    rst = 1'b0;

    // Regfile write/read, x0 discard
    wb_write(5'd5, 32'hDEADBEEF);
    wb_write(5'd0, 32'h00001234);
    exp_q.push_back(pk(64'h1, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0, 5'd1, 1'b0));
    send(64'h1, 5'd5, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
    wb_load = 1'b1; wb_rd = 5'd0; wb_data = 32'h00001234;
    exp_q.push_back(pk(64'h2, 32'h0, 32'hDEADBEEF, 5'd0, 5'd5, 5'd2, 1'b0));
    send(64'h2, 5'd0, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0);
    wb_load = 1'b0;

    // Same-cycle bypass into rs2
    wb_load = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
    exp_q.push_back(pk(64'h3, 32'h0, 32'hA5A5A5A5, 5'd0, 5'd7, 5'd4, 1'b0));
    send(64'h3, 5'd0, 5'd7, 5'd4, 1'b1, 1'b1, 1'b0);
    wb_load = 1'b0;

    // Back-to-back flow, one per cycle
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pk(64'(10 + i), 32'hA5A5A5A5, 32'hDEADBEEF, 5'd7, 5'd5, 5'(20 + i), 1'b0));
      send(64'(10 + i), 5'd7, 5'd5, 5'(20 + i), 1'b1, 1'b1, 1'b0);
    end

    // Load-use: rs1 hazard, rs2 hazard, unused source exempt
    load_use(64'h20, 5'd3, 64'h21, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF);
    load_use(64'h22, 5'd7, 64'h23, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF);
    load_use(64'h24, 5'd3, 64'h25, 5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
    step();

    // Backpressure hold with writeback refresh of rs2
    exp_q.push_back(pk(64'h30, 32'hDEADBEEF, 32'h00000055, 5'd5, 5'd9, 5'd10, 1'b0));
    send(64'h30, 5'd5, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0);
    ex_ready = 1'b0;
    exp_q.push_back(pk(64'h31, 32'h00000055, 32'h0, 5'd9, 5'd0, 5'd11, 1'b0));
    set_id(64'h31, 5'd9, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    wb_load = 1'b1; wb_rd = 5'd9; wb_data = 32'h00000055;
    @(negedge clk);
    chk("hold_id_ready_0", 64'(id_ready), 64'd0);
    chk("hold_ctrl_0", ex_ctrl, 64'h30);
    step();
    wb_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_refresh_rs2", 64'(ex_rs2_val), 64'h55);
      chk("hold_ctrl", ex_ctrl, 64'h30);
      chk("hold_id_ready", 64'(id_ready), 64'd0);
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("release_id_ready", 64'(id_ready), 64'd1);
    step();
    id_valid = 1'b0;
    step();
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    chk("stat_bubbles", 64'(stat_bubbles), 64'd2);
    chk("stat_holds", 64'(stat_holds), 64'd3);
    step();
`endif

    // Flush together with a load-use hazard (neither instruction reaches execute)
    send(64'h40, 5'd5, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
    set_id(64'h41, 5'd3, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_haz_id_ready", 64'(id_ready), 64'd1);
    step();
    flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("flush_haz_valid", 64'(ex_valid), 64'd0);
    step();

    // Flush while held
    send(64'h50, 5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    ex_ready = 1'b0;
    @(negedge clk);
    chk("held_before_flush", 64'(ex_valid), 64'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_held_valid", 64'(ex_valid), 64'd0);
    step();

    // Asynchronous reset in the middle of a hold
    send(64'h60, 5'd5, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(ex_valid), 64'd0);
    chk("async_rst_ctrl", ex_ctrl, 64'd0);
    step();
    rst = 1'b0;
    ex_ready = 1'b1;
    exp_q.push_back(pk(64'h61, 32'h0, 32'h0, 5'd5, 5'd7, 5'd16, 1'b0));
    send(64'h61, 5'd5, 5'd7, 5'd16, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
